// File: rtl/emu_rst_seq_pkg.sv
// Shared types and defaults for the emulation reset sequencer.
// Optional debounce of the switch and button inputs is enabled by EMU_RST_DEBOUNCE_EN.
package emu_rst_seq_pkg;

  localparam int SEQ_STATE_W = 3;

  localparam int DEF_POR_CYCLES = 10;
  localparam int DEF_KEY_CYCLES = 16;
  localparam int DEF_SOC_CYCLES = 32;
  localparam int DEF_DEB_CYCLES = 1000;
  localparam int DEF_CNT_W      = 16;

  // Encodings are visible on seq_state_o (LEDs), so they are fixed.
  typedef enum logic [SEQ_STATE_W-1:0] {
    WAIT_LOCK = 3'd0,
    POR_HOLD  = 3'd1,
    KEY_HOLD  = 3'd2,
    SOC_HOLD  = 3'd3,
    RUN       = 3'd4
  } seq_state_e;

endpackage

// File: rtl/emu_input_filter.sv
// Two-flop synchronizer for an asynchronous board input, with an optional
// stability filter when EMU_RST_DEBOUNCE_EN is defined.
module emu_input_filter
  import emu_rst_seq_pkg::*;
`ifdef EMU_RST_DEBOUNCE_EN
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
)
`endif
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic filt_o
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], async_i};
    end
  end

`ifdef EMU_RST_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             filt_reg;
  logic [CNT_W-1:0] deb_cnt_reg;

  // The filtered level only follows after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_reg    <= 1'b0;
      deb_cnt_reg <= '0;
    end else if (sync_reg[1] != filt_reg) begin
      if (deb_cnt_reg == DEB_LAST) begin
        filt_reg    <= sync_reg[1];
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
    end else begin
      deb_cnt_reg <= '0;
    end
  end

  assign filt_o = filt_reg;
`else
  assign filt_o = sync_reg[1];
`endif

endmodule

// File: rtl/emu_reset_sequencer.sv
// Reset release and core start sequencer for the FPGA emulation top.
// Defining EMU_RST_DEBOUNCE_EN debounces fetch_sw_i and key_btn_i (lock is never debounced).
module emu_reset_sequencer
  import emu_rst_seq_pkg::*;
#(
  parameter int POR_CYCLES = DEF_POR_CYCLES,
  parameter int KEY_CYCLES = DEF_KEY_CYCLES,
  parameter int SOC_CYCLES = DEF_SOC_CYCLES,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pll_locked_i,
  input  logic                   fetch_sw_i,
  input  logic                   key_btn_i,
  output logic                   rst_por_no,
  output logic                   rst_key_no,
  output logic                   soc_rst_no,
  output logic                   fetch_en_o,
  output logic [SEQ_STATE_W-1:0] seq_state_o,
  output logic                   busy_o
);

  if (POR_CYCLES < 1 || KEY_CYCLES < 1 || SOC_CYCLES < 1 || DEB_CYCLES < 1 ||
      longint'(POR_CYCLES) >= (longint'(1) << CNT_W) ||
      longint'(KEY_CYCLES) >= (longint'(1) << CNT_W) ||
      longint'(SOC_CYCLES) >= (longint'(1) << CNT_W) ||
      longint'(DEB_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_cfg
    $error("emu_reset_sequencer: cycle parameters must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOC_LAST = CNT_W'(SOC_CYCLES - 1);

  // Bit 0: fetch switch, bit 1: key button.
  logic [1:0] board_raw;
  logic [1:0] board_filt;

  assign board_raw = {key_btn_i, fetch_sw_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_board_in
    emu_input_filter
`ifdef EMU_RST_DEBOUNCE_EN
      #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W))
`endif
      u_filter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (board_raw[gi]),
        .filt_o  (board_filt[gi])
      );
  end

  logic [1:0] lock_sync_reg;
  logic       lock_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_sync_reg <= '0;
    end else begin
      lock_sync_reg <= {lock_sync_reg[0], pll_locked_i};
    end
  end

  assign lock_sync = lock_sync_reg[1];

  logic fetch_filt;
  logic key_filt;
  logic key_filt_d_reg;
  logic key_press;

  assign fetch_filt = board_filt[0];
  assign key_filt   = board_filt[1];
  assign key_press  = key_filt & ~key_filt_d_reg;

  seq_state_e                 state_reg;
  logic [CNT_W-1:0]           cnt_reg;
  logic                       rst_por_n_reg;
  logic                       rst_key_n_reg;
  logic                       soc_rst_n_reg;
  logic                       fetch_en_reg;
  logic                       busy_reg;
  logic [SEQ_STATE_W-1:0]     seq_state_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= WAIT_LOCK;
      cnt_reg        <= '0;
      key_filt_d_reg <= 1'b0;
      rst_por_n_reg  <= 1'b0;
      rst_key_n_reg  <= 1'b0;
      soc_rst_n_reg  <= 1'b0;
      fetch_en_reg   <= 1'b0;
      busy_reg       <= 1'b1;
      seq_state_reg  <= WAIT_LOCK;
    end else begin
      key_filt_d_reg <= key_filt;
      cnt_reg        <= cnt_reg + 1'b1;

      // Lock loss is checked first so it wins over key presses and expiry.
      case (state_reg)
        WAIT_LOCK: begin
          if (lock_sync) begin
            state_reg <= POR_HOLD;
            cnt_reg   <= '0;
          end
        end
        POR_HOLD: begin
          if (!lock_sync) begin
            state_reg <= WAIT_LOCK;
          end else if (cnt_reg == POR_LAST) begin
            state_reg <= KEY_HOLD;
            cnt_reg   <= '0;
          end
        end
        KEY_HOLD: begin
          if (!lock_sync) begin
            state_reg <= WAIT_LOCK;
          end else if (cnt_reg == KEY_LAST) begin
            state_reg <= SOC_HOLD;
            cnt_reg   <= '0;
          end
        end
        SOC_HOLD: begin
          if (!lock_sync) begin
            state_reg <= WAIT_LOCK;
          end else if (cnt_reg == SOC_LAST) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          if (!lock_sync) begin
            state_reg <= WAIT_LOCK;
          end else if (key_press) begin
            state_reg <= KEY_HOLD;
            cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= WAIT_LOCK;
        end
      endcase

      // Outputs decode the current state, so they trail each transition by one cycle.
      rst_por_n_reg <= state_reg inside {KEY_HOLD, SOC_HOLD, RUN};
      rst_key_n_reg <= state_reg inside {SOC_HOLD, RUN};
      soc_rst_n_reg <= (state_reg == RUN);
      fetch_en_reg  <= (state_reg == RUN) && fetch_filt;
      busy_reg      <= (state_reg != RUN);
      seq_state_reg <= state_reg;
    end
  end

  assign rst_por_no  = rst_por_n_reg;
  assign rst_key_no  = rst_key_n_reg;
  assign soc_rst_no  = soc_rst_n_reg;
  assign fetch_en_o  = fetch_en_reg;
  assign busy_o      = busy_reg;
  assign seq_state_o = seq_state_reg;

endmodule

// File: tb/tb_emu_reset_sequencer.sv
// Scoreboard bench for emu_reset_sequencer: expected output changes are queued with
// their cycle stamps and a negedge monitor pops one entry per observed change.
module tb_emu_reset_sequencer;

`ifdef EMU_RST_DEBOUNCE_EN
  localparam int D = 8;
`else
  localparam int D = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       pll_locked_i = 1'b0;
  logic       fetch_sw_i = 1'b0;
  logic       key_btn_i = 1'b0;
  logic       rst_por_no;
  logic       rst_key_no;
  logic       soc_rst_no;
  logic       fetch_en_o;
  logic [2:0] seq_state_o;
  logic       busy_o;

  emu_reset_sequencer #(
    .POR_CYCLES (10),
    .KEY_CYCLES (16),
    .SOC_CYCLES (32),
    .DEB_CYCLES (8),
    .CNT_W      (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .pll_locked_i (pll_locked_i),
    .fetch_sw_i   (fetch_sw_i),
    .key_btn_i    (key_btn_i),
    .rst_por_no   (rst_por_no),
    .rst_key_no   (rst_key_no),
    .soc_rst_no   (soc_rst_no),
    .fetch_en_o   (fetch_en_o),
    .seq_state_o  (seq_state_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] vec;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [7:0] prev_vec;

  // {state[2:0], por_n, key_n, soc_n, fetch_en, busy}
  function automatic logic [7:0] mk(int st, bit por, bit key, bit soc, bit fe, bit busy);
    logic [2:0] s;
    s = 3'(st);
    return {s, por, key, soc, fe, busy};
  endfunction

  function automatic logic [7:0] out_vec();
    return {seq_state_o, rst_por_no, rst_key_no, soc_rst_no, fetch_en_o, busy_o};
  endfunction

  localparam logic [7:0] V_WAIT = 8'b000_000_0_1;
  localparam logic [7:0] V_POR  = 8'b001_000_0_1;
  localparam logic [7:0] V_KEY  = 8'b010_100_0_1;
  localparam logic [7:0] V_SOC  = 8'b011_110_0_1;
  localparam logic [7:0] V_RUN0 = 8'b100_111_0_0;
  localparam logic [7:0] V_RUN1 = 8'b100_111_1_0;

  task automatic expect_at(input int at, input logic [7:0] v, input string tag);
    exp_t e;
    e.cyc = at;
    e.vec = v;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int max, input string tag);
    for (int i = 0; i < max && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: %0d events still pending, required 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Full release sequence after lock is seen (or reset released with lock high) at base.
  task automatic push_seq(input int b, input bit fe, input string tag);
    expect_at(b + 4,  V_POR, {tag, "_por"});
    expect_at(b + 14, V_KEY, {tag, "_key"});
    expect_at(b + 30, V_SOC, {tag, "_soc"});
    expect_at(b + 62, fe ? V_RUN1 : V_RUN0, {tag, "_run"});
  endtask

  always @(negedge clk) begin
    logic [7:0] cur;
    exp_t       e;
    if (mon_en) begin
      cur = out_vec();
      if (cur !== prev_vec) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got vec=%b at cyc %0d, required no change", cur, cyc);
        end else begin
          e = sb_q.pop_front();
          if (cur !== e.vec || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s: got vec=%b cyc=%0d, required vec=%b cyc=%0d",
                     e.tag, cur, cyc, e.vec, e.cyc);
          end else begin
            $display("ok %s: vec=%b cyc=%0d", e.tag, cur, cyc);
          end
        end
        prev_vec = cur;
      end
    end
  end

  initial begin
    int b, k, l, r, s;
    #1 rst_i = 1'b1;
    pll_locked_i = 1'b1;
    @(negedge clk);
    checks++;
    if (out_vec() !== V_WAIT) begin
      errors++;
      $display("FAIL reset_state: got vec=%b, required vec=%b", out_vec(), V_WAIT);
    end else begin
      $display("ok reset_state: vec=%b", out_vec());
    end
    prev_vec = V_WAIT;
    mon_en   = 1'b1;
    wait_neg(2);

    // Power-up sequence with fetch switch low.
    b = cyc;
    rst_i = 1'b0;
    push_seq(b, 1'b0, "pwrup");
    drain(80, "pwrup");

    // Fetch switch toggles in RUN.
    wait_neg(3);
    b = cyc;
    fetch_sw_i = 1'b1;
    expect_at(b + 3 + D, V_RUN1, "fetch_rise");
    drain(20 + D, "fetch_rise");
    wait_neg(4);
    b = cyc;
    fetch_sw_i = 1'b0;
    expect_at(b + 3 + D, V_RUN0, "fetch_fall");
    drain(20 + D, "fetch_fall");
    wait_neg(2);
    b = cyc;
    fetch_sw_i = 1'b1;
    expect_at(b + 3 + D, V_RUN1, "fetch_rise2");
    drain(20 + D, "fetch_rise2");

    // Key press in RUN re-runs key/SoC holds; a second press in KEY_HOLD is ignored.
    wait_neg(2);
    k = cyc;
    key_btn_i = 1'b1;
    expect_at(k + 4 + D,  V_KEY,  "keyseq_key");
    expect_at(k + 20 + D, V_SOC,  "keyseq_soc");
    expect_at(k + 52 + D, V_RUN1, "keyseq_run");
    wait_neg(D + 2);
    key_btn_i = 1'b0;
    wait_neg(12 - D);
    key_btn_i = 1'b1;
    wait_neg(D + 2);
    key_btn_i = 1'b0;
    drain(80, "keyseq");

    // Lock loss in SOC_HOLD coinciding with a filtered key edge.
    wait_neg(2);
    k = cyc;
    key_btn_i = 1'b1;
    expect_at(k + 4 + D,  V_KEY, "lockkey_key");
    expect_at(k + 20 + D, V_SOC, "lockkey_soc");
    wait_neg(D + 2);
    key_btn_i = 1'b0;
    wait_neg(28 - D);
    key_btn_i = 1'b1;
    wait_neg(D);
    l = cyc;
    pll_locked_i = 1'b0;
    expect_at(l + 4, V_WAIT, "lockkey_drop");
    wait_neg(2);
    key_btn_i = 1'b0;
    drain(30, "lockkey");
    wait_neg(3);
    r = cyc;
    pll_locked_i = 1'b1;
    push_seq(r, 1'b1, "relock");
    drain(80, "relock");

    // Lock loss in RUN, relock, then a one-cycle rst_i pulse mid-POR_HOLD.
    wait_neg(2);
    l = cyc;
    pll_locked_i = 1'b0;
    expect_at(l + 4, V_WAIT, "run_drop");
    drain(20, "run_drop");
    wait_neg(2);
    r = cyc;
    pll_locked_i = 1'b1;
    expect_at(r + 4, V_POR, "pre_rst_por");
    drain(20, "pre_rst_por");
    wait_neg(3);
    @(posedge clk);
    #2 rst_i = 1'b1;
    expect_at(cyc, V_WAIT, "async_rst");
    #1;
    checks++;
    if (out_vec() !== V_WAIT) begin
      errors++;
      $display("FAIL async_rst_immediate: got vec=%b, required vec=%b", out_vec(), V_WAIT);
    end else begin
      $display("ok async_rst_immediate: vec=%b", out_vec());
    end
    @(negedge clk);
    @(negedge clk);
    b = cyc;
    rst_i = 1'b0;
    push_seq(b, 1'b1, "post_rst");
    drain(80, "post_rst");

`ifdef EMU_RST_DEBOUNCE_EN
    // Bouncing key: 1,0,1 at 3-cycle intervals then a 10-cycle high gives one press.
    wait_neg(2);
    s = cyc;
    key_btn_i = 1'b1;
    expect_at(s + 10 + D, V_KEY,  "bounce_key");
    expect_at(s + 26 + D, V_SOC,  "bounce_soc");
    expect_at(s + 58 + D, V_RUN1, "bounce_run");
    wait_neg(3);
    key_btn_i = 1'b0;
    wait_neg(3);
    key_btn_i = 1'b1;
    wait_neg(10);
    key_btn_i = 1'b0;
    drain(90, "bounce");
`else
    s = 0;
`endif

    // Quiet tail: any further output change is reported by the monitor.
    wait_neg(20);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
